// File: rtl/e203_ifu_ir_queue_pkg.sv
// Shared sizing helpers and defaults for the IFU-to-EXU instruction queue.
package e203_ifu_ir_queue_pkg;

  localparam int IRQ_DEPTH_DEF   = 2;
  localparam int IRQ_PC_W_DEF    = 32;
  localparam int IRQ_IR_W_DEF    = 32;
  localparam int IRQ_RFIDX_W_DEF = 5;

  // Single-bit fields: pc_vld, misalgn, buserr, prdt_taken, muldiv_b2b
  localparam int IRQ_FLAG_BITS = 5;

  function automatic int irq_pld_w(input int ir_w, input int pc_w, input int rfidx_w);
    return ir_w + pc_w + 2 * rfidx_w + IRQ_FLAG_BITS;
  endfunction

  function automatic int irq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int irq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/e203_ifu_ir_queue_fifo_ctrl.sv
// Pointer, occupancy and flush bookkeeping for the instruction queue storage.
module e203_irq_fifo_ctrl
  import e203_ifu_ir_queue_pkg::*;
#(
  parameter int DEPTH = IRQ_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic [irq_ptr_w(DEPTH)-1:0]   wr_ptr_o,
  output logic [irq_ptr_w(DEPTH)-1:0]   rd_ptr_o,
  output logic [irq_cnt_w(DEPTH)-1:0]   cnt_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int PTR_W = irq_ptr_w(DEPTH);
  localparam int CNT_W = irq_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flush wins over any same-cycle pop; pointers wrap naturally since DEPTH is 2^PTR_W
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign cnt_o    = cnt_q;
  assign full_o   = (cnt_q == DEPTH_C);
  assign empty_o  = (cnt_q == '0);

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
  a_cnt_bound:    assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= DEPTH_C);
`endif

endmodule

// File: rtl/e203_ifu_ir_queue.sv
// IFU-to-EXU instruction queue with registered output and flush.
// Define E203_IR_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module e203_ifu_ir_queue
  import e203_ifu_ir_queue_pkg::*;
#(
  parameter int DEPTH   = IRQ_DEPTH_DEF,
  parameter int PC_W    = IRQ_PC_W_DEF,
  parameter int IR_W    = IRQ_IR_W_DEF,
  parameter int RFIDX_W = IRQ_RFIDX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [IR_W-1:0]          i_ir,
  input  logic [PC_W-1:0]          i_pc,
  input  logic                     i_pc_vld,
  input  logic                     i_misalgn,
  input  logic                     i_buserr,
  input  logic [RFIDX_W-1:0]       i_rs1idx,
  input  logic [RFIDX_W-1:0]       i_rs2idx,
  input  logic                     i_prdt_taken,
  input  logic                     i_muldiv_b2b,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [IR_W-1:0]          o_ir,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_pc_vld,
  output logic                     o_misalgn,
  output logic                     o_buserr,
  output logic [RFIDX_W-1:0]       o_rs1idx,
  output logic [RFIDX_W-1:0]       o_rs2idx,
  output logic                     o_prdt_taken,
  output logic                     o_muldiv_b2b,
  input  logic                     flush_req,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     q_empty
);

  localparam int PTR_W = irq_ptr_w(DEPTH);
  localparam int CNT_W = irq_cnt_w(DEPTH);
  localparam int PLD_W = irq_pld_w(IR_W, PC_W, RFIDX_W);

  logic [PLD_W-1:0] mem_q [DEPTH];
  logic [PLD_W-1:0] mem_d [DEPTH];
  logic [PLD_W-1:0] in_pld, head_pld, out_pld;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full, empty;
  logic             push, wr_en, fifo_pop;

  assign in_pld = {i_ir, i_pc, i_pc_vld, i_misalgn, i_buserr,
                   i_rs1idx, i_rs2idx, i_prdt_taken, i_muldiv_b2b};

  // Empty queue presents an all-zero payload rather than stale storage
  assign head_pld = empty ? '0 : mem_q[rd_ptr];
  assign push     = i_valid & i_ready & ~flush_req;
  assign fifo_pop = ~empty & o_ready;

`ifdef E203_IR_QUEUE_BYPASS_EN
  logic bypass_act;
  assign bypass_act = empty & i_valid;
  assign o_valid    = bypass_act ? ~flush_req : ~empty;
  assign out_pld    = bypass_act ? in_pld : head_pld;
  assign i_ready    = ~full | (empty & o_ready);
  // A beat taken straight through by the EXU is never stored
  assign wr_en      = push & ~(bypass_act & o_ready);
`else
  assign o_valid = ~empty;
  assign out_pld = head_pld;
  assign i_ready = ~full;
  assign wr_en   = push;
`endif

  e203_irq_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (wr_en),
    .pop_i    (fifo_pop),
    .flush_i  (flush_req),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .cnt_o    (cnt),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = in_pld;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {o_ir, o_pc, o_pc_vld, o_misalgn, o_buserr,
          o_rs1idx, o_rs2idx, o_prdt_taken, o_muldiv_b2b} = out_pld;

  assign q_cnt   = cnt;
  assign q_empty = empty;

endmodule
